// File: rtl/nibble_class_tally.sv
// Per-frame statistics over a classified nibble stream: re-checks the prime/div3
// flags, tallies counts and the longest prime run, and emits one record per frame.
module nibble_class_tally #(
    parameter int  FRAME_LEN = 8,
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_a,
    input  logic          in_p,
    input  logic          in_d,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_len,
    output logic [CW-1:0] out_prime_cnt,
    output logic [CW-1:0] out_div3_cnt,
    output logic [CW-1:0] out_both_cnt,
    output logic [CW-1:0] out_max_run,
    output logic          out_err,
    output logic          err_sticky
);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] FULL     = CW'(FRAME_LEN);
    localparam logic [CW-1:0] LAST_GAP = CW'(FRAME_LEN - 1);

    // Independent reference classification, one table bit per nibble value.
    logic [15:0] prime_tbl;
    logic [15:0] div3_tbl;

    for (genvar gi = 0; gi < 16; gi++) begin : g_ref
        assign prime_tbl[gi] = (gi == 2) || (gi == 3) || (gi == 5) ||
                               (gi == 7) || (gi == 11) || (gi == 13);
        assign div3_tbl[gi]  = ((gi % 3) == 0);
    end

    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] prime_q, prime_d;
    logic [CW-1:0] div3_q,  div3_d;
    logic [CW-1:0] both_q,  both_d;
    logic [CW-1:0] run_q,   run_d;
    logic [CW-1:0] max_q,   max_d;
    logic          ferr_q,  ferr_d;

    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_len_q,   out_len_d;
    logic [CW-1:0] out_prime_q, out_prime_d;
    logic [CW-1:0] out_div3_q,  out_div3_d;
    logic [CW-1:0] out_both_q,  out_both_d;
    logic [CW-1:0] out_max_q,   out_max_d;
    logic          out_err_q,   out_err_d;
    logic          sticky_q,    sticky_d;

    logic          accept;
    logic          mismatch;
    logic          full_close;
    logic          flush_close;
    logic          close;
    logic [CW-1:0] cnt_inc, prime_inc, div3_inc, both_inc, run_inc, max_inc;
    logic          ferr_inc;

    // Depends only on registered state, so out_ready never reaches in_ready.
    assign in_ready = !(out_valid_q && (cnt_q == LAST_GAP));

    always_comb begin
        accept    = in_valid && in_ready;
        mismatch  = accept && ((in_p != prime_tbl[in_a]) || (in_d != div3_tbl[in_a]));

        cnt_inc   = accept                   ? cnt_q + ONE   : cnt_q;
        prime_inc = (accept && in_p)         ? prime_q + ONE : prime_q;
        div3_inc  = (accept && in_d)         ? div3_q + ONE  : div3_q;
        both_inc  = (accept && in_p && in_d) ? both_q + ONE  : both_q;
        run_inc   = accept ? (in_p ? run_q + ONE : '0) : run_q;
        max_inc   = (run_inc > max_q) ? run_inc : max_q;
        ferr_inc  = ferr_q || mismatch;

        // cnt_inc != 0 covers both "frame already non-empty" and "sample this cycle".
        full_close  = accept && (cnt_inc == FULL);
        flush_close = flush && !out_valid_q && (cnt_inc != '0);
        close       = full_close || flush_close;

        cnt_d   = close ? '0 : cnt_inc;
        prime_d = close ? '0 : prime_inc;
        div3_d  = close ? '0 : div3_inc;
        both_d  = close ? '0 : both_inc;
        run_d   = close ? '0 : run_inc;
        max_d   = close ? '0 : max_inc;
        ferr_d  = close ? 1'b0 : ferr_inc;

        out_len_d   = close ? cnt_inc   : out_len_q;
        out_prime_d = close ? prime_inc : out_prime_q;
        out_div3_d  = close ? div3_inc  : out_div3_q;
        out_both_d  = close ? both_inc  : out_both_q;
        out_max_d   = close ? max_inc   : out_max_q;
        out_err_d   = close ? ferr_inc  : out_err_q;

        // A close is impossible while a record is held, so load and drain never collide.
        if (close)
            out_valid_d = 1'b1;
        else if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        else
            out_valid_d = out_valid_q;

        sticky_d = sticky_q || mismatch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            prime_q     <= '0;
            div3_q      <= '0;
            both_q      <= '0;
            run_q       <= '0;
            max_q       <= '0;
            ferr_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_len_q   <= '0;
            out_prime_q <= '0;
            out_div3_q  <= '0;
            out_both_q  <= '0;
            out_max_q   <= '0;
            out_err_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prime_q     <= prime_d;
            div3_q      <= div3_d;
            both_q      <= both_d;
            run_q       <= run_d;
            max_q       <= max_d;
            ferr_q      <= ferr_d;
            out_valid_q <= out_valid_d;
            out_len_q   <= out_len_d;
            out_prime_q <= out_prime_d;
            out_div3_q  <= out_div3_d;
            out_both_q  <= out_both_d;
            out_max_q   <= out_max_d;
            out_err_q   <= out_err_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_len       = out_len_q;
    assign out_prime_cnt = out_prime_q;
    assign out_div3_cnt  = out_div3_q;
    assign out_both_cnt  = out_both_q;
    assign out_max_run   = out_max_q;
    assign out_err       = out_err_q;
    assign err_sticky    = sticky_q;

endmodule

// File: tb/tb_nibble_class_tally.sv
// Randomized and directed stimulus for nibble_class_tally, checked every cycle
// against a frame-level model built from queues of accepted samples.
module tb_nibble_class_tally;

    localparam int FL = 8;
    localparam int CW = $clog2(FL + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [3:0]    in_a;
    logic          in_p, in_d, flush;
    logic          out_valid, out_ready;
    logic [CW-1:0] out_len, out_prime_cnt, out_div3_cnt, out_both_cnt, out_max_run;
    logic          out_err, err_sticky;

    nibble_class_tally #(.FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_p(in_p), .in_d(in_d), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_len(out_len), .out_prime_cnt(out_prime_cnt), .out_div3_cnt(out_div3_cnt),
        .out_both_cnt(out_both_cnt), .out_max_run(out_max_run),
        .out_err(out_err), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_prime(input int a);
        return (a == 2) || (a == 3) || (a == 5) || (a == 7) || (a == 11) || (a == 13);
    endfunction

    function automatic bit is_div3(input int a);
        return (a % 3) == 0;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int len; int pc; int dc; int bc; int mr; bit err;
    } rec_t;

    int   fa[$];
    bit   fp[$];
    bit   fd[$];
    bit   m_pending = 1'b0;
    bit   m_sticky  = 1'b0;
    rec_t m_rec;

    function automatic rec_t summarize();
        rec_t r;
        int run = 0;
        r = '{default: 0};
        r.len = fa.size();
        foreach (fa[i]) begin
            if (fp[i]) r.pc++;
            if (fd[i]) r.dc++;
            if (fp[i] && fd[i]) r.bc++;
            run = fp[i] ? run + 1 : 0;
            if (run > r.mr) r.mr = run;
            if (fp[i] != is_prime(fa[i]) || fd[i] != is_div3(fa[i])) r.err = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        bit pend, rdy, acc;
        if (!rst_n) begin
            fa.delete(); fp.delete(); fd.delete();
            m_pending = 1'b0;
            m_sticky  = 1'b0;
        end else begin
            pend = m_pending;
            rdy  = !(pend && fa.size() == FL - 1);
            acc  = in_valid && rdy;
            if (acc) begin
                fa.push_back(int'(in_a)); fp.push_back(in_p); fd.push_back(in_d);
                if (in_p != is_prime(int'(in_a)) || in_d != is_div3(int'(in_a))) m_sticky = 1'b1;
            end
            if (pend && out_ready) begin
                $display("record len=%0d prime=%0d div3=%0d both=%0d max_run=%0d err=%0d",
                         m_rec.len, m_rec.pc, m_rec.dc, m_rec.bc, m_rec.mr, m_rec.err);
                m_pending = 1'b0;
            end
            if ((acc && fa.size() == FL) || (flush && !pend && fa.size() > 0)) begin
                m_rec = summarize();
                m_pending = 1'b1;
                fa.delete(); fp.delete(); fd.delete();
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, !(m_pending && fa.size() == FL - 1));
            chk("out_valid", out_valid, m_pending);
            chk("err_sticky", err_sticky, m_sticky);
            if (m_pending) begin
                chk("out_len", out_len, m_rec.len);
                chk("out_prime_cnt", out_prime_cnt, m_rec.pc);
                chk("out_div3_cnt", out_div3_cnt, m_rec.dc);
                chk("out_both_cnt", out_both_cnt, m_rec.bc);
                chk("out_max_run", out_max_run, m_rec.mr);
                chk("out_err", out_err, m_rec.err);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int a, input bit p, input bit d);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = 4'(a); in_p = p; in_d = d;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_ok(input int a);
        send(a, is_prime(a), is_div3(a));
    endtask

    task automatic pulse_flush();
        @(negedge clk) flush = 1'b1;
        @(negedge clk) flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rec(input string tag, input int len, input int pc, input int dc,
                            input int bc, input int mr, input bit err);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        if (out_valid) begin
            chk({tag, "_len"}, out_len, len);
            chk({tag, "_prime"}, out_prime_cnt, pc);
            chk({tag, "_div3"}, out_div3_cnt, dc);
            chk({tag, "_both"}, out_both_cnt, bc);
            chk({tag, "_max_run"}, out_max_run, mr);
            chk({tag, "_err"}, out_err, err);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_p = 1'b0; in_d = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_err_sticky", err_sticky, 0);
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        for (int a = 0; a < 8; a++) send_ok(a);
        wait_rec("f_lo", 8, 4, 3, 1, 2, 0);
        for (int a = 8; a < 16; a++) send_ok(a);
        wait_rec("f_hi", 8, 2, 3, 0, 1, 0);
        chk("sticky_clean", err_sticky, 0);

        for (int a = 0; a < 8; a++) begin
            if (a == 4) send(4, 1'b1, 1'b0);
            else send_ok(a);
        end
        wait_rec("f_bad", 8, 5, 3, 1, 4, 1);
        for (int a = 0; a < 8; a++) send_ok(a);
        wait_rec("f_after_bad", 8, 4, 3, 1, 2, 0);
        chk("sticky_held", err_sticky, 1);
        idle(2);

        // Output stall: the 8th sample must wait for the drain.
        out_ready = 1'b0;
        for (int a = 0; a < 8; a++) send_ok(a);
        wait_rec("stall_first", 8, 4, 3, 1, 2, 0);
        for (int a = 8; a < 15; a++) send_ok(a);
        fork
            send_ok(15);
            begin
                idle(3);
                chk("stall_in_ready", in_ready, 0);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        wait_rec("stall_second", 8, 2, 3, 0, 1, 0);
        out_ready = 1'b1;
        idle(2);

        send_ok(2); send_ok(3); send_ok(5);
        pulse_flush();
        wait_rec("flush3", 3, 3, 1, 1, 3, 0);
        idle(2);
        pulse_flush();
        chk("flush_empty", out_valid, 0);
        idle(1);
        chk("flush_empty2", out_valid, 0);

        out_ready = 1'b0;
        send_ok(1); send_ok(2);
        pulse_flush();
        wait_rec("flush2", 2, 1, 0, 0, 1, 0);
        send_ok(4);
        pulse_flush();
        chk("flush_ignored_len", out_len, 2);
        out_ready = 1'b1;
        idle(2);
        pulse_flush();
        wait_rec("flush1", 1, 0, 0, 0, 0, 0);
        idle(2);

        // Reset with a pending record and a partial frame.
        out_ready = 1'b0;
        for (int a = 0; a < 8; a++) send_ok(a);
        for (int a = 0; a < 5; a++) send_ok(a);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_len", out_len, 0);
        chk("midrst_prime", out_prime_cnt, 0);
        chk("midrst_max_run", out_max_run, 0);
        chk("midrst_sticky", err_sticky, 0);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int a = 8; a < 16; a++) send_ok(a);
        wait_rec("post_rst_frame", 8, 2, 3, 0, 1, 0);

        // Random traffic with occasional bad flags, flushes and stalls.
        for (int c = 0; c < 600; c++) begin
            int a;
            @(negedge clk);
            a = int'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 4'(a);
            in_p      = is_prime(a) ^ ($urandom_range(0, 15) == 0);
            in_d      = is_div3(a) ^ ($urandom_range(0, 15) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
